// File: rtl/bcd_align_subtract_serial_pkg.sv
// Shared constants and state encoding for the serial BCD
// align/subtract stage.
package bcd_align_subtract_serial_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int DIGITS      = 7;
  localparam int EXT         = 2;
  localparam int WORK_DIGITS = DIGITS + EXT;
  localparam int WORK_W      = WORK_DIGITS * BCD_DIGIT_W;
  localparam int MR_W        = DIGITS * BCD_DIGIT_W;

  localparam int GRS_G_HI = 8;
  localparam int GRS_G_LO = 5;
  localparam int GRS_R_HI = 4;
  localparam int GRS_R_LO = 1;
  localparam int GRS_S    = 0;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    SUB,
    NEG,
    DONE
  } state_t;

endpackage

// File: rtl/bcd_align_subtract_serial_digit_sub.sv
// One-digit BCD subtractor with borrow chain:
// d = a - b - borrow_in, corrected by +10 when it borrows.
module bcd_digit_sub
  import bcd_align_subtract_serial_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] a,
  input  logic [BCD_DIGIT_W-1:0] b,
  input  logic                   borrow_in,
  output logic [BCD_DIGIT_W-1:0] d,
  output logic                   borrow_out
);

  logic [BCD_DIGIT_W:0] diff;

  always_comb begin
    diff = {1'b0, a} - {1'b0, b}
         - {{BCD_DIGIT_W{1'b0}}, borrow_in};
    borrow_out = diff[BCD_DIGIT_W];
    d = borrow_out
      ? diff[BCD_DIGIT_W-1:0] + BCD_DIGIT_W'(10)
      : diff[BCD_DIGIT_W-1:0];
  end

endmodule

// File: rtl/bcd_align_subtract_serial.sv
// Digit-serial aligner and ten's-complement BCD subtractor
// producing Mr plus guard/round/sticky for rounding.
module bcd_align_subtract_serial
  import bcd_align_subtract_serial_pkg::*;
#(
  parameter int SHIFT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MR_W-1:0]    Ma,
  input  logic [MR_W-1:0]    Mb,
  input  logic [SHIFT_W-1:0] ediff,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [MR_W-1:0]    Mr,
  output logic [8:0]         GRS,
  output logic               neg
);

  localparam int DW = BCD_DIGIT_W;
  localparam logic [3:0] LAST = 4'(WORK_DIGITS - 1);

  state_t state, nxt;

  logic [WORK_W-1:0] a_q;
  logic [WORK_W-1:0] w_q;
  logic [WORK_W-1:0] w_nxt;
  logic              s_q;
  logic              bq;
  logic [3:0]        cnt;
  logic [3:0]        cnt_init;
  logic [MR_W-1:0]   mr_q;
  logic [8:0]        grs_q;
  logic              neg_q;

  logic [DW-1:0] sa;
  logic [DW-1:0] sd;
  logic          sbin;
  logic          sbout;

  bcd_digit_sub u_sub (
    .a          (sa),
    .b          (w_q[DW-1:0]),
    .borrow_in  (sbin),
    .d          (sd),
    .borrow_out (sbout)
  );

  // NEG reuses the subtractor as 0 - W; sticky feeds only
  // the first SUB digit.
  always_comb begin
    sa    = (state == NEG) ? '0 : a_q[DW-1:0];
    sbin  = (cnt == '0) ? (state == SUB && s_q) : bq;
    w_nxt = {sd, w_q[WORK_W-1:DW]};
    cnt_init = (ediff > SHIFT_W'(WORK_DIGITS))
             ? 4'(WORK_DIGITS)
             : ediff[3:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (in_valid)
          nxt = (cnt_init != '0) ? ALIGN : SUB;
      end
      ALIGN: begin
        if (cnt == 4'd1) nxt = SUB;
      end
      SUB: begin
        if (cnt == LAST) nxt = sbout ? NEG : DONE;
      end
      NEG: begin
        if (cnt == LAST) nxt = DONE;
      end
      DONE: begin
        if (out_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      w_q   <= '0;
      s_q   <= 1'b0;
      bq    <= 1'b0;
      cnt   <= '0;
      mr_q  <= '0;
      grs_q <= '0;
      neg_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q <= {Ma, {(EXT*DW){1'b0}}};
            w_q <= {Mb, {(EXT*DW){1'b0}}};
            s_q <= 1'b0;
            bq  <= 1'b0;
            cnt <= cnt_init;
          end
        end
        ALIGN: begin
          w_q <= {{DW{1'b0}}, w_q[WORK_W-1:DW]};
          s_q <= s_q | (w_q[DW-1:0] != '0);
          cnt <= cnt - 4'd1;
        end
        SUB, NEG: begin
          w_q <= w_nxt;
          a_q <= {{DW{1'b0}}, a_q[WORK_W-1:DW]};
          bq  <= sbout;
          if (cnt == LAST) begin
            cnt <= '0;
            if (state == SUB) neg_q <= sbout;
            if (state == NEG || !sbout) begin
              mr_q <= w_nxt[WORK_W-1:EXT*DW];
              grs_q[GRS_G_HI:GRS_G_LO] <= w_nxt[2*DW-1:DW];
              grs_q[GRS_R_HI:GRS_R_LO] <= w_nxt[DW-1:0];
              grs_q[GRS_S] <= s_q;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign Mr        = mr_q;
  assign GRS       = grs_q;
  assign neg       = neg_q;

endmodule

// File: tb/tb_bcd_align_subtract_serial.sv
// Randomized and directed bench for bcd_align_subtract_serial
// against an integer-arithmetic reference model.
module tb_bcd_align_subtract_serial;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [27:0] Ma = '0;
  logic [27:0] Mb = '0;
  logic [7:0]  ediff = '0;
  logic        in_ready;
  logic        out_valid;
  logic [27:0] Mr;
  logic [8:0]  GRS;
  logic        neg;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  bcd_align_subtract_serial dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Ma        (Ma),
    .Mb        (Mb),
    .ediff     (ediff),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Mr        (Mr),
    .GRS       (GRS),
    .neg       (neg)
  );

  function automatic longint b2i(input logic [27:0] b);
    longint v = 0;
    for (int i = 6; i >= 0; i--) v = v * 10 + longint'(b[i*4 +: 4]);
    return v;
  endfunction

  function automatic logic [27:0] i2b(input longint v);
    logic [27:0] b;
    longint t = v;
    for (int i = 0; i < 7; i++) begin
      b[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return b;
  endfunction

  // Reference: exact integer subtraction of the aligned,
  // truncated subtrahend with sticky as an extra unit.
  task automatic model(input logic [27:0] ma, input logic [27:0] mb,
                       input logic [7:0] ed,
                       output logic [27:0] emr, output logic [8:0] egrs,
                       output logic eneg, output int elat);
    longint a, b, p, r;
    int k;
    logic s;
    k = (ed > 9) ? 9 : int'(ed);
    a = b2i(ma) * 100;
    b = b2i(mb) * 100;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    s = (b % p) != 0;
    r = a - b / p - (s ? 1 : 0);
    eneg = (r < 0);
    if (r < 0) r = -r;
    emr  = i2b(r / 100);
    egrs = {4'((r / 10) % 10), 4'(r % 10), s};
    elat = 1 + k + 9 + (eneg ? 9 : 0);
  endtask

  // Drives one operation; lat counts the accept cycle as 1.
  task automatic do_op(input logic [27:0] ma, input logic [27:0] mb,
                       input logic [7:0] ed, input int hold,
                       output logic [27:0] gmr, output logic [8:0] ggrs,
                       output logic gneg, output int lat,
                       output bit stable, output logic ov_after);
    @(negedge clk);
    Ma = ma; Mb = mb; ediff = ed;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      #1 lat++;
    end
    gmr = Mr; ggrs = GRS; gneg = neg;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      if (Mr !== gmr || GRS !== ggrs || neg !== gneg ||
          out_valid !== 1'b1 || in_ready !== 1'b0)
        stable = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    ov_after = out_valid;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1 0",
               in_ready, out_valid);
    end else passed++;
    total++;
    if (Mr !== 28'h0 || GRS !== 9'h0 || neg !== 1'b0) begin
      $display("FAIL reset_out: Mr=%h GRS=%h neg=%b want 0",
               Mr, GRS, neg);
    end else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [27:0] tma [5] = '{28'h1000000, 28'h5000000, 28'h5000000,
                             28'h0000003, 28'h1000000};
    logic [27:0] tmb [5] = '{28'h0000001, 28'h1234567, 28'h1234567,
                             28'h0000005, 28'h9999999};
    logic [7:0]  ted [5] = '{8'd0, 8'd2, 8'd3, 8'd0, 8'd12};
    logic [27:0] xmr [5] = '{28'h0999999, 28'h4987654, 28'h4998765,
                             28'h0000002, 28'h0999999};
    logic [8:0]  xgrs[5] = '{9'h000, {4'h3, 4'h3, 1'b0},
                             {4'h4, 4'h3, 1'b1}, 9'h000,
                             {4'h9, 4'h9, 1'b1}};
    logic        xneg[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int          xlat[5] = '{10, 12, 13, 19, 19};
    logic [27:0] gmr;
    logic [8:0]  ggrs;
    logic        gneg, ova;
    int          lat;
    bit          st;
    for (int i = 0; i < 5; i++) begin
      do_op(tma[i], tmb[i], ted[i], 0, gmr, ggrs, gneg, lat, st, ova);
      total++;
      if (gmr !== xmr[i] || ggrs !== xgrs[i] || gneg !== xneg[i]) begin
        $display("FAIL dir%0d_result: Mr=%h GRS=%h neg=%b want %h %h %b",
                 i, gmr, ggrs, gneg, xmr[i], xgrs[i], xneg[i]);
      end else passed++;
      total++;
      if (lat !== xlat[i]) begin
        $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, xlat[i]);
      end else passed++;
    end
  endtask

  task automatic test_random();
    logic [27:0] ma, mb, gmr, emr;
    logic [8:0]  ggrs, egrs;
    logic [7:0]  ed;
    logic        gneg, eneg, ova;
    int          lat, elat;
    bit          st;
    for (int n = 0; n < 40; n++) begin
      ma = '0; mb = '0;
      for (int i = 0; i < 7; i++) begin
        ma[i*4 +: 4] = 4'($urandom_range(0, 9));
        mb[i*4 +: 4] = 4'($urandom_range(0, 9));
      end
      ed = 8'($urandom_range(0, 12));
      if (ed != 0) ma[27:24] = 4'($urandom_range(1, 9));
      if (n % 8 == 0) begin mb = ma; ed = 8'd0; end
      model(ma, mb, ed, emr, egrs, eneg, elat);
      do_op(ma, mb, ed, 0, gmr, ggrs, gneg, lat, st, ova);
      total++;
      if (gmr !== emr || ggrs !== egrs || gneg !== eneg) begin
        $display("FAIL rand%0d_result: Ma=%h Mb=%h ed=%0d got %h %h %b want %h %h %b",
                 n, ma, mb, ed, gmr, ggrs, gneg, emr, egrs, eneg);
      end else passed++;
      total++;
      if (lat !== elat) begin
        $display("FAIL rand%0d_latency: got %0d want %0d", n, lat, elat);
      end else passed++;
    end
  endtask

  task automatic test_backpressure();
    logic [27:0] gmr;
    logic [8:0]  ggrs;
    logic        gneg, ova;
    int          lat;
    bit          st;
    do_op(28'h5000000, 28'h1234567, 8'd3, 5, gmr, ggrs, gneg, lat, st, ova);
    total++;
    if (st !== 1'b1) begin
      $display("FAIL bp_stable: held outputs changed (stable=%b want 1)", st);
    end else passed++;
    total++;
    if (gmr !== 28'h4998765 || ggrs !== {4'h4, 4'h3, 1'b1}) begin
      $display("FAIL bp_result: Mr=%h GRS=%h want 4998765 087", gmr, ggrs);
    end else passed++;
    total++;
    if (ova !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1",
               ova, in_ready);
    end else passed++;
  endtask

  task automatic test_back_to_back();
    logic [27:0] gmr, emr;
    logic [8:0]  ggrs, egrs;
    logic        gneg, eneg, ova;
    int          lat, elat;
    bit          st;
    model(28'h7654321, 28'h0000009, 8'd1, emr, egrs, eneg, elat);
    do_op(28'h7654321, 28'h0000009, 8'd1, 0, gmr, ggrs, gneg, lat, st, ova);
    do_op(28'h2000000, 28'h3000000, 8'd0, 0, gmr, ggrs, gneg, lat, st, ova);
    model(28'h2000000, 28'h3000000, 8'd0, emr, egrs, eneg, elat);
    total++;
    if (gmr !== emr || ggrs !== egrs || gneg !== eneg || lat !== elat) begin
      $display("FAIL b2b_second: got %h %h %b lat %0d want %h %h %b lat %0d",
               gmr, ggrs, gneg, lat, emr, egrs, eneg, elat);
    end else passed++;
  endtask

  task automatic test_reset_mid();
    logic [27:0] gmr;
    logic [8:0]  ggrs;
    logic        gneg, ova;
    int          lat, seen;
    bit          st;
    @(negedge clk);
    Ma = 28'h9000000; Mb = 28'h1111111; ediff = 8'd0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL midrst_state: in_ready=%b out_valid=%b want 1 0",
               in_ready, out_valid);
    end else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1 if (out_valid === 1'b1) seen++;
    end
    total++;
    if (seen !== 0 || Mr !== 28'h0) begin
      $display("FAIL midrst_noout: out_valid cycles=%0d Mr=%h want 0 0",
               seen, Mr);
    end else passed++;
    do_op(28'h5000000, 28'h1234567, 8'd2, 0, gmr, ggrs, gneg, lat, st, ova);
    total++;
    if (gmr !== 28'h4987654 || ggrs !== {4'h3, 4'h3, 1'b0} ||
        gneg !== 1'b0 || lat !== 12) begin
      $display("FAIL midrst_fresh: got %h %h %b lat %0d want 4987654 066 0 lat 12",
               gmr, ggrs, gneg, lat);
    end else passed++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
